// File: rtl/operand_sequencer.sv
// operand_sequencer
// -----------------
// Collects eight 32-bit operand words from an upstream valid/ready stream
// into the operand registers i1..i8, fires a one-cycle start pulse to a
// compute core, waits (bounded by TIMEOUT cycles) for the core's done flag,
// then presents the captured result downstream on a valid/ready handshake.
// A core that never answers yields out_data = 0 with out_err = 1.
//
// Ports
//   clk        : sole clock, rising edge
//   rst        : synchronous, active-high reset
//   in_valid   : upstream operand word valid
//   in_data    : upstream operand word (32 bits)
//   in_ready   : block accepts an operand word this cycle (LOAD only)
//   start      : registered one-cycle launch pulse to the core
//   i1..i8     : operand registers driven to the core
//   result_in  : result from the core
//   done_in    : core completion flag (only looked at in WAIT)
//   out_valid  : captured result available
//   out_data   : captured result (0 on timeout)
//   out_err    : out_data invalid because the core timed out
//   out_ready  : downstream accepts out_data
//   busy       : high in every state except LOAD
module operand_sequencer #(
    parameter int TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    output logic        in_ready,
    output logic        start,
    output logic [31:0] i1,
    output logic [31:0] i2,
    output logic [31:0] i3,
    output logic [31:0] i4,
    output logic [31:0] i5,
    output logic [31:0] i6,
    output logic [31:0] i7,
    output logic [31:0] i8,
    input  logic [31:0] result_in,
    input  logic        done_in,
    output logic        out_valid,
    output logic [31:0] out_data,
    output logic        out_err,
    input  logic        out_ready,
    output logic        busy
);

    // Timeout counter only needs to reach TIMEOUT-1.
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_OUT    = 2'd3
    } state_t;

    state_t          state_r;
    state_t          nxt_state_s;
    logic [2:0]      cnt_r;
    logic [TW-1:0]   tcnt_r;
    logic [31:0]     ops_r [8];
    logic            start_r;
    logic [31:0]     out_data_r;
    logic            out_err_r;

    logic            load_fire_s;
    logic            capture_s;
    logic            timeout_s;
    logic            release_s;

    // Next-state and per-cycle event decode.
    always_comb begin
        nxt_state_s = state_r;
        load_fire_s = 1'b0;
        capture_s   = 1'b0;
        timeout_s   = 1'b0;
        release_s   = 1'b0;
        case (state_r)
            ST_LOAD: begin
                if (in_valid) begin
                    load_fire_s = 1'b1;
                    if (cnt_r == 3'd7) begin
                        nxt_state_s = ST_LAUNCH;
                    end else begin
                        nxt_state_s = ST_LOAD;
                    end
                end else begin
                    nxt_state_s = ST_LOAD;
                end
            end
            ST_LAUNCH: begin
                nxt_state_s = ST_WAIT;
            end
            ST_WAIT: begin
                // A real completion wins over a timeout on the same cycle.
                if (done_in) begin
                    capture_s   = 1'b1;
                    nxt_state_s = ST_OUT;
                end else if (tcnt_r == TLAST) begin
                    timeout_s   = 1'b1;
                    nxt_state_s = ST_OUT;
                end else begin
                    nxt_state_s = ST_WAIT;
                end
            end
            ST_OUT: begin
                if (out_ready) begin
                    release_s   = 1'b1;
                    nxt_state_s = ST_LOAD;
                end else begin
                    nxt_state_s = ST_OUT;
                end
            end
            default: begin
                nxt_state_s = ST_LOAD;
            end
        endcase
    end

    // State register and registered launch pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_LOAD;
            start_r <= 1'b0;
        end else begin
            state_r <= nxt_state_s;
            start_r <= (nxt_state_s == ST_LAUNCH);
        end
    end

    // Operand slot counter; wraps to 0 on the eighth transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= 3'd0;
        end else if (release_s) begin
            cnt_r <= 3'd0;
        end else if (load_fire_s) begin
            cnt_r <= cnt_r + 3'd1;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Timeout counter: cleared while launching so it starts at 0 in WAIT.
    always_ff @(posedge clk) begin
        if (rst) begin
            tcnt_r <= '0;
        end else if (state_r == ST_LAUNCH) begin
            tcnt_r <= '0;
        end else if ((state_r == ST_WAIT) && !done_in && !timeout_s) begin
            tcnt_r <= tcnt_r + TW'(1);
        end else begin
            tcnt_r <= tcnt_r;
        end
    end

    // Operand registers: written only by LOAD transfers.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 8; k++) begin
                ops_r[k] <= 32'd0;
            end
        end else if (load_fire_s) begin
            ops_r[cnt_r] <= in_data;
        end else begin
            for (int k = 0; k < 8; k++) begin
                ops_r[k] <= ops_r[k];
            end
        end
    end

    // Result capture: core result on done, zero plus error flag on timeout.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_r <= 32'd0;
            out_err_r  <= 1'b0;
        end else if (capture_s) begin
            out_data_r <= result_in;
            out_err_r  <= 1'b0;
        end else if (timeout_s) begin
            out_data_r <= 32'd0;
            out_err_r  <= 1'b1;
        end else begin
            out_data_r <= out_data_r;
            out_err_r  <= out_err_r;
        end
    end

    // Handshake flags decode from the state register only.
    assign in_ready  = (state_r == ST_LOAD);
    assign busy      = (state_r != ST_LOAD);
    assign out_valid = (state_r == ST_OUT);
    assign start     = start_r;
    assign out_data  = out_data_r;
    assign out_err   = out_err_r;

    assign i1 = ops_r[0];
    assign i2 = ops_r[1];
    assign i3 = ops_r[2];
    assign i4 = ops_r[3];
    assign i5 = ops_r[4];
    assign i6 = ops_r[5];
    assign i7 = ops_r[6];
    assign i8 = ops_r[7];

endmodule

// File: tb/tb_operand_sequencer.sv
// Bench for operand_sequencer (TIMEOUT = 16): a transaction-level model
// checked against the DUT every cycle, plus literal checks that pin the model.
module tb_operand_sequencer;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = 32'd0;
    logic        in_ready;
    logic        start;
    logic [31:0] i1, i2, i3, i4, i5, i6, i7, i8;
    logic [31:0] result_in = 32'd0;
    logic        done_in = 1'b0;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_err;
    logic        out_ready = 1'b0;
    logic        busy;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    operand_sequencer #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .start(start),
        .i1(i1), .i2(i2), .i3(i3), .i4(i4), .i5(i5), .i6(i6), .i7(i7), .i8(i8),
        .result_in(result_in), .done_in(done_in),
        .out_valid(out_valid), .out_data(out_data), .out_err(out_err),
        .out_ready(out_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    // Model: what the block is doing, in terms of words held and waiting time.
    bit          m_accepting = 1'b1;
    int          m_words     = 0;
    logic [31:0] m_ops [8]   = '{default: 32'd0};
    bit          m_start     = 1'b0;
    bit          m_waiting   = 1'b0;
    int          m_waited    = 0;
    bit          m_have      = 1'b0;
    logic [31:0] m_data      = 32'd0;
    bit          m_err       = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_accepting = 1'b1; m_words = 0; m_start = 1'b0;
            m_waiting = 1'b0; m_waited = 0; m_have = 1'b0;
            m_data = 32'd0; m_err = 1'b0;
            for (int k = 0; k < 8; k++) m_ops[k] = 32'd0;
        end else if (m_accepting) begin
            if (in_valid) begin
                m_ops[m_words] = in_data;
                m_words = m_words + 1;
                if (m_words == 8) begin
                    m_words = 0;
                    m_accepting = 1'b0;
                    m_start = 1'b1;
                end
            end
        end else if (m_start) begin
            m_start = 1'b0;
            m_waiting = 1'b1;
            m_waited = 0;
        end else if (m_waiting) begin
            m_waited = m_waited + 1;
            if (done_in) begin
                m_data = result_in; m_err = 1'b0;
                m_waiting = 1'b0; m_have = 1'b1;
            end else if (m_waited == TO) begin
                m_data = 32'd0; m_err = 1'b1;
                m_waiting = 1'b0; m_have = 1'b1;
            end
        end else if (m_have && out_ready) begin
            m_have = 1'b0;
            m_accepting = 1'b1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready",  {31'd0, in_ready},  {31'd0, m_accepting});
            chk("busy",      {31'd0, busy},      {31'd0, !m_accepting});
            chk("start",     {31'd0, start},     {31'd0, m_start});
            chk("out_valid", {31'd0, out_valid}, {31'd0, m_have});
            chk("out_err",   {31'd0, out_err},   {31'd0, m_err});
            chk("out_data",  out_data, m_data);
            chk("i1", i1, m_ops[0]); chk("i2", i2, m_ops[1]);
            chk("i3", i3, m_ops[2]); chk("i4", i4, m_ops[3]);
            chk("i5", i5, m_ops[4]); chk("i6", i6, m_ops[5]);
            chk("i7", i7, m_ops[6]); chk("i8", i8, m_ops[7]);
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic load8(input logic [31:0] w [8], input bit keep);
        in_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            in_data = w[k];
            cyc(1);
        end
        in_valid = keep;
    endtask

    // Wait (bounded) for out_valid, then accept it.
    task automatic drain();
        int n;
        n = 0;
        while (!out_valid && n < 40) begin
            cyc(1);
            n++;
        end
        checks++;
        if (!out_valid) begin
            errors++;
            $display("FAIL drain_wait actual=out_valid_low required=out_valid_high");
        end
        out_ready = 1'b1;
        cyc(1);
        out_ready = 1'b0;
    endtask

    logic [31:0] wa [8] = '{32'd1, 32'd2, 32'd1, 32'd1, 32'd3, 32'd0, 32'd1, 32'd1};
    logic [31:0] wb [8];
    logic [31:0] wc [8];

    initial begin
        for (int k = 0; k < 8; k++) begin
            wb[k] = 32'h100 + 32'(k);
            wc[k] = 32'd21 + 32'(k);
        end
        cyc(2);
        rst = 1'b0;
        chk_en = 1'b1;
        chk("lit_reset_in_ready", {31'd0, in_ready}, 32'd1);
        chk("lit_reset_out_valid", {31'd0, out_valid}, 32'd0);

        // Basic flow with in_valid held high throughout.
        load8(wa, 1'b1);
        in_data = 32'd99;
        chk("lit_start_hi", {31'd0, start}, 32'd1);
        chk("lit_i2", i2, 32'd2);
        chk("lit_i5", i5, 32'd3);
        chk("lit_i6", i6, 32'd0);
        cyc(1);
        chk("lit_start_lo", {31'd0, start}, 32'd0);
        chk("lit_in_ready_lo", {31'd0, in_ready}, 32'd0);
        cyc(4);
        result_in = 32'hDEADBEEF;
        done_in = 1'b1;
        cyc(1);
        done_in = 1'b0;
        result_in = 32'd0;
        for (int k = 0; k < 4; k++) begin
            chk("lit_cap_valid", {31'd0, out_valid}, 32'd1);
            chk("lit_cap_data", out_data, 32'hDEADBEEF);
            chk("lit_cap_err", {31'd0, out_err}, 32'd0);
            if (k < 3) cyc(1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        cyc(1);
        out_ready = 1'b0;
        chk("lit_busy_after", {31'd0, busy}, 32'd0);
        chk("lit_i8_held", i8, 32'd1);

        // Gapped input.
        for (int k = 0; k < 8; k++) begin
            in_valid = 1'b1;
            in_data = 32'h40 + 32'(k);
            cyc(1);
            in_valid = 1'b0;
            in_data = 32'hFFFF_FFFF;
            if (k < 7) begin
                chk("lit_gap_nostart", {31'd0, start}, 32'd0);
                cyc(1);
            end
        end
        chk("lit_gap_start", {31'd0, start}, 32'd1);
        chk("lit_gap_i8", i8, 32'h47);
        cyc(3);
        result_in = 32'h5;
        done_in = 1'b1;
        cyc(1);
        done_in = 1'b0;
        drain();

        // Timeout with no done.
        load8(wb, 1'b0);
        cyc(1);
        cyc(15);
        chk("lit_to_not_yet", {31'd0, out_valid}, 32'd0);
        cyc(1);
        chk("lit_to_valid", {31'd0, out_valid}, 32'd1);
        chk("lit_to_err", {31'd0, out_err}, 32'd1);
        chk("lit_to_data", out_data, 32'd0);
        drain();

        // Done on the last allowed WAIT cycle wins.
        load8(wb, 1'b0);
        cyc(16);
        result_in = 32'h1234_5678;
        done_in = 1'b1;
        cyc(1);
        done_in = 1'b0;
        chk("lit_edge_err", {31'd0, out_err}, 32'd0);
        chk("lit_edge_data", out_data, 32'h1234_5678);
        drain();

        // Reset after 4 transfers, then again during WAIT.
        in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_data = 32'hA0 + 32'(k);
            cyc(1);
        end
        in_valid = 1'b0;
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        chk("lit_rst1_i1", i1, 32'd0);
        chk("lit_rst1_ready", {31'd0, in_ready}, 32'd1);
        load8(wb, 1'b0);
        cyc(3);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        chk("lit_rst2_busy", {31'd0, busy}, 32'd0);
        chk("lit_rst2_i8", i8, 32'd0);
        load8(wc, 1'b0);
        chk("lit_reload_i1", i1, 32'd21);
        chk("lit_reload_i8", i8, 32'd28);
        cyc(2);
        result_in = 32'h77;
        done_in = 1'b1;
        cyc(1);
        done_in = 1'b0;
        drain();

        // Stray done during LOAD and LAUNCH.
        done_in = 1'b1;
        result_in = 32'hBAD0_BAD0;
        cyc(2);
        load8(wa, 1'b0);
        chk("lit_stray_launch", {31'd0, start}, 32'd1);
        cyc(1);
        done_in = 1'b0;
        chk("lit_stray_nocap", {31'd0, out_valid}, 32'd0);
        cyc(2);
        result_in = 32'h33;
        done_in = 1'b1;
        cyc(1);
        done_in = 1'b0;
        chk("lit_stray_data", out_data, 32'h33);
        drain();

        cyc(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
